// File: rtl/seg_ram_display.sv
// Periodically fetches a 4-byte RAM window into a shadow buffer, commits it
// atomically to the display register and scans it onto an 8-digit 7-segment display.
module seg_ram_display #(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned SCAN_PERIOD  = 50000,
    parameter int unsigned FETCH_PERIOD = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              freeze,
    output logic              busy,
    output logic [7:0]        an,
    output logic [6:0]        seg
);

    localparam int unsigned FT_W = $clog2(FETCH_PERIOD);
    localparam int unsigned ST_W = $clog2(SCAN_PERIOD);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [FT_W-1:0]   timer_q, timer_d;
    logic [ST_W-1:0]   scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        dig_q, dig_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       disp_q, disp_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              busy_q, busy_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              fetch_tick;
    logic              scan_wrap;
    logic [2:0]        dig_sel;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Next-state logic: fetch timer, fetch FSM and digit scanner.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        rd_req_d  = rd_req_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;

        fetch_tick = (timer_q == FT_W'(FETCH_PERIOD - 1));
        timer_d    = fetch_tick ? '0 : timer_q + FT_W'(1);

        case (state_q)
            IDLE: begin
                if (fetch_tick) begin
                    state_d   = REQ;
                    idx_d     = 2'd0;
                    rd_req_d  = 1'b1;
                    rd_addr_d = BASE_A;
                    busy_d    = 1'b1;
                end
            end
            REQ: begin
                // Address is held until the arbiter grants; no timeout by design.
                if (rd_gnt) begin
                    shadow_d[{idx_q, 3'b000} +: 8] = rd_data;
                    idx_d     = idx_q + 2'd1;
                    rd_addr_d = BASE_A + ADDR_W'(idx_q) + ADDR_W'(1);
                    if (idx_q == 2'd3) begin
                        state_d  = COMMIT;
                        rd_req_d = 1'b0;
                    end
                end
            end
            COMMIT: begin
                if (!freeze) begin
                    disp_d = shadow_q;
                end
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                rd_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        scan_wrap = (scan_q == ST_W'(SCAN_PERIOD - 1));
        scan_d    = scan_wrap ? '0 : scan_q + ST_W'(1);
        dig_sel   = scan_wrap ? dig_q + 3'd1 : dig_q;
        dig_d     = dig_sel;
        // Segments refresh every cycle so a commit shows up on the next edge.
        an_d      = ~(8'd1 << dig_sel);
        seg_d     = glyph(disp_q[{dig_sel, 2'b00} +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            scan_q    <= '0;
            idx_q     <= 2'd0;
            dig_q     <= 3'd0;
            shadow_q  <= 32'd0;
            disp_q    <= 32'd0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= BASE_A;
            busy_q    <= 1'b0;
            an_q      <= 8'b1111_1110;
            seg_q     <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            dig_q     <= dig_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign rd_req  = rd_req_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
